// File: rtl/store_checker.sv
// Store checker: matches processor stores against configured (address, data) expectations.
// Define STORE_CHECKER_ANYORDER_EN to accept expected stores in any order.
module store_checker #(
    parameter  int DATA_W     = 32,
    parameter  int NUM_CHECKS = 4,
    parameter  int TIMEOUT    = 1000,
    parameter  int IGN_LO     = 96,
    parameter  int IGN_HI     = 96,
    localparam int CW         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_idx,
    input  logic [DATA_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [CW:0]       cfg_num,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CW:0]       match_cnt,
    output logic [DATA_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [CW:0] NUM_MAX = (CW + 1)'(NUM_CHECKS);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_e;

    state_e            state_q, state_d;
    logic [CW:0]       match_cnt_q, match_cnt_d;
    logic [CW:0]       num_q, num_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [DATA_W-1:0] slot_addr_q [NUM_CHECKS];
    logic [DATA_W-1:0] slot_data_q [NUM_CHECKS];

    logic [NUM_CHECKS-1:0] slot_hit;
    logic                  hit;
    logic                  in_window;
    logic [CW:0]           start_num;

    // NOTE: the expectation slots are reset explicitly, so a run started right after
    // reset compares against zeros rather than stale or X contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
        end else if (cfg_we && state_q != S_RUN) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (cfg_idx == CW'(i)) begin
                    slot_addr_q[i] <= cfg_addr;
                    slot_data_q[i] <= cfg_data;
                end
            end
        end
    end

    always_comb begin
        slot_hit = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            slot_hit[i] = (slot_addr_q[i] == DataAdr) && (slot_data_q[i] == WriteData)
                          && ((CW + 1)'(i) < num_q);
        end
    end

`ifdef STORE_CHECKER_ANYORDER_EN
    logic [NUM_CHECKS-1:0] done_q, done_d, done_set;

    // Lowest-indexed not-yet-matched slot wins.
    always_comb begin
        hit      = 1'b0;
        done_set = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (!hit && slot_hit[i] && !done_q[i]) begin
                hit         = 1'b1;
                done_set[i] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (match_cnt_q == (CW + 1)'(i)) hit = slot_hit[i];
        end
    end
`endif

    assign in_window = (DataAdr >= DATA_W'(IGN_LO)) && (DataAdr <= DATA_W'(IGN_HI));
    assign start_num = (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;

    // NOTE: every next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        num_d       = num_q;
        timer_d     = timer_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
`ifdef STORE_CHECKER_ANYORDER_EN
        done_d      = done_q;
`endif
        case (state_q)
            S_RUN: begin
                timer_d = timer_q + TW'(1);
                if (MemWrite && hit) begin
                    match_cnt_d = match_cnt_q + (CW + 1)'(1);
`ifdef STORE_CHECKER_ANYORDER_EN
                    done_d      = done_q | done_set;
`endif
                    if (match_cnt_d == num_q) state_d = S_PASS;
                end else if (MemWrite && !in_window) begin
                    state_d     = S_FAIL;
                    fail_addr_d = DataAdr;
                    fail_data_d = WriteData;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_TMO;
                end
            end
            default: begin
                if (start) begin
                    num_d       = start_num;
                    match_cnt_d = '0;
                    timer_d     = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
`ifdef STORE_CHECKER_ANYORDER_EN
                    done_d      = '0;
`endif
                    state_d     = (start_num == '0) ? S_PASS : S_RUN;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            match_cnt_q <= '0;
            num_q       <= '0;
            timer_q     <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
`ifdef STORE_CHECKER_ANYORDER_EN
            done_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            num_q       <= num_d;
            timer_q     <= timer_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
`ifdef STORE_CHECKER_ANYORDER_EN
            done_q      <= done_d;
`endif
        end
    end

    assign busy      = (state_q == S_RUN);
    assign pass      = (state_q == S_PASS);
    assign fail      = (state_q == S_FAIL);
    assign timeout   = (state_q == S_TMO);
    assign match_cnt = match_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_store_checker.sv
// Scoreboard bench for store_checker: expected run outcomes are queued as stimulus is
// driven and compared when the run ends (busy drops).
module tb_store_checker;

    localparam int DW  = 32;
    localparam int NC  = 4;
    localparam int TMO = 50;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          reset, cfg_we, start, MemWrite;
    logic [CW-1:0] cfg_idx;
    logic [DW-1:0] cfg_addr, cfg_data, DataAdr, WriteData;
    logic [CW:0]   cfg_num;
    logic          busy, pass, fail, timeout;
    logic [CW:0]   match_cnt;
    logic [DW-1:0] fail_addr, fail_data;

    always #5 clk = ~clk;

    store_checker #(.DATA_W(DW), .NUM_CHECKS(NC), .TIMEOUT(TMO), .IGN_LO(96), .IGN_HI(96)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_num(cfg_num), .start(start), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData), .busy(busy), .pass(pass), .fail(fail),
        .timeout(timeout), .match_cnt(match_cnt), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    typedef struct {
        string         tag;
        logic          p, f, t;
        logic [CW:0]   mcnt;
        logic [DW-1:0] fa, fd;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic cfg_slot(input int idx, input int a, input int d);
        cfg_we = 1'b1; cfg_idx = CW'(idx); cfg_addr = DW'(a); cfg_data = DW'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int num);
        start = 1'b1; cfg_num = (CW + 1)'(num);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic store(input int a, input int d);
        MemWrite = 1'b1; DataAdr = DW'(a); WriteData = DW'(d);
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic expect_end(input string tag, input logic p, input logic f, input logic t,
                              input int mcnt, input int fa, input int fd, input int lat);
        exp_t e;
        e.tag = tag; e.p = p; e.f = f; e.t = t;
        e.mcnt = (CW + 1)'(mcnt); e.fa = DW'(fa); e.fd = DW'(fd); e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        exp_t e;
        int   n;
        e = exp_q.pop_front();
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({e.tag, "_busy"}, busy, 0);
        check({e.tag, "_lat"}, n, e.lat);
        check({e.tag, "_pass"}, pass, e.p);
        check({e.tag, "_fail"}, fail, e.f);
        check({e.tag, "_tmo"}, timeout, e.t);
        check({e.tag, "_mcnt"}, match_cnt, e.mcnt);
        check({e.tag, "_faddr"}, fail_addr, e.fa);
        check({e.tag, "_fdata"}, fail_data, e.fd);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        cfg_num = '0; start = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_tmo", timeout, 0);
        check("rst_mcnt", match_cnt, 0);

        // Scratch store ignored, then the expected store passes.
        cfg_slot(0, 100, 25);
        do_start(1);
        check("run_busy", busy, 1);
        DataAdr = 100; WriteData = 25;
        @(negedge clk);
        check("idle_bus_mcnt", match_cnt, 0);
        store(96, 7);
        check("scratch_busy", busy, 1);
        store(100, 25);
        expect_end("basic", 1, 0, 0, 1, 0, 0, 0);
        drain(20);

        // Right address, wrong data; fail info holds through later stores.
        do_start(1);
        store(100, 24);
        expect_end("wrongdata", 0, 1, 0, 0, 100, 24, 0);
        drain(20);
        store(200, 1);
        expect_end("fail_hold", 0, 1, 0, 0, 100, 24, 0);
        drain(20);

        // Timeout exactly TMO cycles after RUN is entered.
        do_start(1);
        expect_end("timeout", 0, 0, 1, 0, 0, 0, TMO);
        drain(200);

        // A match on the final cycle beats timeout.
        do_start(1);
        repeat (TMO - 1) @(negedge clk);
        check("edge_busy", busy, 1);
        store(100, 25);
        expect_end("edge_match", 1, 0, 0, 1, 0, 0, 0);
        drain(20);

        // Out-of-order stores.
        cfg_slot(1, 104, 9);
        do_start(2);
        store(104, 9);
`ifdef STORE_CHECKER_ANYORDER_EN
        store(100, 25);
        expect_end("reorder", 1, 0, 0, 2, 0, 0, 0);
`else
        expect_end("reorder", 0, 1, 0, 0, 104, 9, 0);
`endif
        drain(20);

        // In order; a slot write attempted during RUN must not take effect.
        do_start(2);
        cfg_slot(0, 1, 1);
        store(100, 25);
        store(104, 9);
        expect_end("inorder", 1, 0, 0, 2, 0, 0, 0);
        drain(20);

        // cfg_num above NUM_CHECKS clamps to NUM_CHECKS.
        cfg_slot(2, 108, 3);
        cfg_slot(3, 112, 4);
        do_start(7);
        store(100, 25);
        store(104, 9);
        store(108, 3);
        check("clamp_busy3", busy, 1);
        check("clamp_mcnt3", match_cnt, 3);
        store(112, 4);
        expect_end("clamp", 1, 0, 0, 4, 0, 0, 0);
        drain(20);

        // Reset mid-run clears state and the slots.
        do_start(2);
        store(100, 25);
        check("mid_mcnt", match_cnt, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_pass", pass, 0);
        check("mrst_fail", fail, 0);
        check("mrst_tmo", timeout, 0);
        check("mrst_mcnt", match_cnt, 0);
        do_start(1);
        store(100, 25);
        expect_end("slots_cleared", 0, 1, 0, 0, 100, 25, 0);
        drain(20);
        do_start(0);
        expect_end("zero_num", 1, 0, 0, 0, 0, 0, 0);
        drain(20);

        // Expectation inside the scratch window takes priority over ignoring.
        cfg_slot(0, 96, 5);
        do_start(1);
        store(96, 6);
        check("win_ignore_busy", busy, 1);
        store(96, 5);
        expect_end("win_match", 1, 0, 0, 1, 0, 0, 0);
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
